// File: rtl/arbitro_rr_mux4a1_if.sv
// arbitro_rr_mux4a1_if: lane inputs, pops and registered output stage of the round-robin mux scheduler
interface arbitro_rr_mux4a1_if #(parameter int BW = 8);
    logic          valid0, valid1, valid2, valid3;
    logic [BW-1:0] data_in0, data_in1, data_in2, data_in3;
    logic          ready_out;
    logic          pop0, pop1, pop2, pop3;
    logic          validout;
    logic [BW-1:0] dataout;
    logic          selectorL1, selectorL2;
    logic [1:0]    lane_id;
    logic [7:0]    cuenta;

    modport master (
        output valid0, valid1, valid2, valid3, data_in0, data_in1, data_in2, data_in3, ready_out,
        input  pop0, pop1, pop2, pop3, validout, dataout, selectorL1, selectorL2, lane_id, cuenta
    );
    modport slave (
        input  valid0, valid1, valid2, valid3, data_in0, data_in1, data_in2, data_in3, ready_out,
        output pop0, pop1, pop2, pop3, validout, dataout, selectorL1, selectorL2, lane_id, cuenta
    );
endinterface

// File: rtl/arbitro_rr_mux4a1.sv
// arbitro_rr_mux4a1: round-robin pick of four valid lanes into a one-entry valid/ready output stage
module arbitro_rr_mux4a1 #(parameter int BW = 8) (
    input logic                clk_4f,
    input logic                reset_L,
    arbitro_rr_mux4a1_if.slave bus
);
    localparam logic [0:0] VACIO = 1'b0;
    localparam logic [0:0] LLENO = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [BW-1:0] dataout_q, dataout_d;
    logic [1:0]    lane_q, lane_d, ptr_q, ptr_d, grant;
    logic [7:0]    cuenta_q, cuenta_d;
    logic [3:0]    valid, pop;
    logic [BW-1:0] data [4];
    logic          any_v, load;

    assign valid   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
    assign data[0] = bus.data_in0;
    assign data[1] = bus.data_in1;
    assign data[2] = bus.data_in2;
    assign data[3] = bus.data_in3;

    // Scan farthest-first so the nearest valid lane after ptr wins.
    always_comb begin
        grant = ptr_q;
        for (int k = 4; k >= 1; k--)
            if (valid[2'(ptr_q + 2'(k))]) grant = 2'(ptr_q + 2'(k));
    end

    assign any_v = |valid;
    assign load  = reset_L && any_v && (state_q == VACIO || bus.ready_out);
    assign pop   = load ? 4'b0001 << grant : 4'b0000;

    always_comb begin
        state_d   = load ? LLENO : (bus.ready_out ? VACIO : state_q);
        dataout_d = load ? data[grant] : dataout_q;
        lane_d    = load ? grant : lane_q;
        ptr_d     = load ? grant : ptr_q;
        cuenta_d  = cuenta_q + {7'b0, state_q == LLENO && bus.ready_out};
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= VACIO;
            dataout_q <= '0;
            lane_q    <= 2'd0;
            ptr_q     <= 2'd3;
            cuenta_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            dataout_q <= dataout_d;
            lane_q    <= lane_d;
            ptr_q     <= ptr_d;
            cuenta_q  <= cuenta_d;
        end
    end

    assign {bus.pop3, bus.pop2, bus.pop1, bus.pop0} = pop;
    assign bus.validout   = state_q;
    assign bus.dataout    = dataout_q;
    assign bus.lane_id    = lane_q;
    assign bus.selectorL1 = lane_q[0];
    assign bus.selectorL2 = lane_q[1];
    assign bus.cuenta     = cuenta_q;
endmodule
